axi_read_slave: RTL and testbench

//   AXI3-style read responder for one slave port. Accepts read-address requests (AR), buffers up to

---
 rtl/axi_read_slave_pkg.sv | 39 +++
 rtl/axi_read_slave_if.sv | 37 +++
 rtl/axi_read_slave_ar_fifo.sv | 43 ++++
 rtl/axi_read_slave.sv | 137 +++++++++++++
 tb/tb_axi_read_slave.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_read_slave_pkg.sv
// Shared codes for the AXI read slave: burst/resp/size encodings, FSM states,
// and the request-legality helper.
// Optional feature macro: AXI_RS_WRAP_EN (WRAP bursts legal for 2/4/8/16 beats).
package axi_rs_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic [1:0] SIZE_1B     = 2'd0;
    localparam logic [1:0] SIZE_2B     = 2'd1;
    localparam logic [1:0] SIZE_4B     = 2'd2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD       = 2'd1;
    localparam logic [1:0] ST_CAP      = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

`ifdef AXI_RS_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    // A request is answered with SLVERR beats when its size or burst code
    // is unusable, or a WRAP burst has an unsupported length.
    function automatic logic ar_err(input logic [1:0] size,
                                    input logic [1:0] burst,
                                    input logic [3:0] len);
        logic len_ok;
        len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (size == 2'd3) || (burst == 2'd3) ||
               ((burst == BURST_WRAP) && (!WRAP_EN || !len_ok));
    endfunction

endpackage

// File: rtl/axi_read_slave_if.sv
// AR + R channel bundle between an interconnect master and the read slave.
interface axi_read_slave_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [1:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [BUS_WIDTH-1:0]  rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_read_slave_ar_fifo.sv
// In-order buffer for accepted read requests. DEPTH must be a power of 2 so
// the pointers wrap naturally.
module axi_rs_ar_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;

    assign rdata = mem[rp];
    assign full  = (cnt == (PW+1)'(DEPTH));
    assign empty = (cnt == '0);

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // entry storage, no reset needed: only read while occupied
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end
endmodule

// File: rtl/axi_read_slave.sv
// AXI3-style read responder: queues AR requests and returns one beat per
// memory read (RD -> CAP -> RESP), with SLVERR beats for unusable requests.
// Optional feature macro: AXI_RS_WRAP_EN (see axi_rs_pkg).
module axi_read_slave
    import axi_rs_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 7,
    parameter int DEPTH      = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    axi_read_slave_if.slave      bus,
    output logic                 mem_cs,
    output logic [MEM_AW-1:0]    mem_raddr,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [MEM_AW-1:0]   addr;
        logic [3:0]          len;
        logic [1:0]          size;
        logic [1:0]          burst;
    } ar_req_t;

    ar_req_t push_req, head;
    logic    fifo_full, fifo_empty, push, pop, head_err;

    logic [1:0]           state;
    logic [ID_WIDTH-1:0]  rid_q;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic [1:0]           rresp_q;
    logic [MEM_AW-1:0]    addr_q, wmask_q;
    logic [3:0]           beats_q;
    logic [1:0]           size_q, burst_q;
    logic                 err_q;

    // lock/cache/prot and the high address bits have no effect here
    logic unused_ar;
    assign unused_ar = ^{bus.araddr[ADDR_WIDTH-1:MEM_AW], bus.arlock, bus.arcache, bus.arprot};

    function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a,
                                                    input logic [1:0]        size,
                                                    input logic [1:0]        burst,
                                                    input logic [MEM_AW-1:0] wmask);
        logic [MEM_AW-1:0] step;
        step = MEM_AW'(1) << size;
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP:  return (a & ~wmask) | ((a + step) & wmask);
            default:     return a + step;
        endcase
    endfunction

    assign push_req = '{id: bus.arid, addr: bus.araddr[MEM_AW-1:0], len: bus.arlen,
                        size: bus.arsize, burst: bus.arburst};
    // no bypass: a full FIFO refuses even when a pop happens the same cycle
    assign push     = bus.arvalid && !fifo_full;
    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign head_err = ar_err(head.size, head.burst, head.len);

    axi_rs_ar_fifo #(.W($bits(ar_req_t)), .DEPTH(DEPTH)) u_ar_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .wdata (push_req),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.arready = !fifo_full;
    assign bus.rvalid  = (state == ST_RESP);
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = (state == ST_RESP) && (beats_q == 4'd0);
    assign mem_cs      = (state == ST_RD);
    assign mem_raddr   = mem_cs ? addr_q : '0;

    // burst sequencer: load a request, then read/capture/respond per beat
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= ST_IDLE;
            rid_q   <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            addr_q  <= '0;
            wmask_q <= '0;
            beats_q <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        rid_q   <= head.id;
                        addr_q  <= head.addr;
                        beats_q <= head.len;
                        size_q  <= head.size;
                        burst_q <= head.burst;
                        err_q   <= head_err;
                        wmask_q <= ((MEM_AW'(head.len) + MEM_AW'(1)) << head.size) - MEM_AW'(1);
                        if (head_err) begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                            state   <= ST_RESP;
                        end else begin
                            state   <= ST_RD;
                        end
                    end
                end
                ST_RD: state <= ST_CAP;
                ST_CAP: begin
                    rdata_q <= mem_rdata;
                    rresp_q <= RESP_OKAY;
                    state   <= ST_RESP;
                end
                default: begin
                    if (bus.rready) begin
                        if (beats_q == 4'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            addr_q  <= next_addr(addr_q, size_q, burst_q, wmask_q);
                            beats_q <= beats_q - 4'd1;
                            state   <= err_q ? ST_RESP : ST_RD;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_slave.sv
// Self-checking bench for axi_read_slave: directed table, multi-cycle corner
// sequences and randomized traffic against a beat-list reference model.
module tb_axi_read_slave;
    import axi_rs_pkg::*;

    localparam int BW = 32, IW = 1, AW = 32, MAW = 7, DEPTH = 2;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic           mem_cs;
    logic [MAW-1:0] mem_raddr;
    logic [BW-1:0]  mem_rdata = '0;

    always #5 clk = ~clk;

    axi_read_slave_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .BUS_WIDTH(BW)) bus ();

    axi_read_slave #(.BUS_WIDTH(BW), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus),
        .mem_cs    (mem_cs),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    // memory returns its own byte address, one cycle after the strobe
    always @(posedge clk) if (mem_cs) mem_rdata <= BW'(mem_raddr);

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [3:0]    len;
        logic [1:0]    size;
        logic [1:0]    burst;
    } ar_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [BW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    typedef struct {
        ar_t           ar;
        int            nb;
        logic [BW-1:0] first;
        logic [BW-1:0] last;
        logic [1:0]    resp;
    } vec_t;

    beat_t exp_q[$], act_q[$];
    int    exp_mq[$], act_mq[$];
    int    checks = 0, fails = 0;
    bit    rr_rand = 1'b0, rr_force = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input beat_t b);
        return 64'({b.id, b.resp, b.last, b.data});
    endfunction

    // reference: expand one request into its full list of beats and memory reads
    function automatic void model_push(input ar_t a);
        int step, start, w, ad;
        bit err;
        beat_t b;
        step  = 1 << a.size;
        start = int'(a.addr) & ((1 << MAW) - 1);
        err   = (a.size == 2'd3) || (a.burst == 2'd3);
        if (a.burst == 2'd2) begin
`ifdef AXI_RS_WRAP_EN
            if (!(a.len inside {4'd1, 4'd3, 4'd7, 4'd15})) err = 1'b1;
`else
            err = 1'b1;
`endif
        end
        w = (int'(a.len) + 1) * step;
        for (int i = 0; i <= int'(a.len); i++) begin
            case (a.burst)
                2'd0:    ad = start;
                2'd2:    ad = (start / w) * w + (start + i * step) % w;
                default: ad = (start + i * step) % (1 << MAW);
            endcase
            b.id   = a.id;
            b.data = err ? '0 : BW'(ad);
            b.resp = err ? 2'd2 : 2'd0;
            b.last = (i == int'(a.len));
            exp_q.push_back(b);
            if (!err) exp_mq.push_back(ad);
        end
    endfunction

    // R-channel backpressure, updated just after each rising edge
    initial begin
        bus.rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_force;
        end
    end

    // collect accepted beats and memory strobes
    always @(negedge clk) begin
        if (bus.rvalid && bus.rready)
            act_q.push_back('{bus.rid, bus.rdata, bus.rresp, bus.rlast});
        if (mem_cs) act_mq.push_back(int'(mem_raddr));
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // called at posedge+1; returns at posedge+1 after the handshake edge
    task automatic send_ar(input ar_t a);
        int n = 0;
        bus.arvalid = 1'b1;
        bus.arid    = a.id;
        bus.araddr  = a.addr;
        bus.arlen   = a.len;
        bus.arsize  = a.size;
        bus.arburst = a.burst;
        bus.arlock  = 2'($urandom);
        bus.arcache = 4'($urandom);
        bus.arprot  = 3'($urandom);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.arready && n < 500);
        chk("ar_accept", 64'(bus.arready), 64'(1));
        @(posedge clk);
        #1;
        if (n < 500) model_push(a);
        bus.arvalid = 1'b0;
    endtask

    task automatic clear_q();
        exp_q.delete();
        act_q.delete();
        exp_mq.delete();
        act_mq.delete();
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (act_q.size() < exp_q.size() && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        chk({nm, " beat_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        chk({nm, " memread_count"}, 64'(act_mq.size()), 64'(exp_mq.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s beat%0d", nm, i), pk(act_q[i]), pk(exp_q[i]));
        for (int i = 0; i < act_mq.size() && i < exp_mq.size(); i++)
            chk($sformatf("%s memaddr%0d", nm, i), 64'(act_mq[i]), 64'(exp_mq[i]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        ar_t  a;
        int   n, m;

        bus.arvalid = 1'b0;
        bus.arid    = '0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsize  = '0;
        bus.arburst = '0;
        bus.arlock  = '0;
        bus.arcache = '0;
        bus.arprot  = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({bus.rvalid, bus.arready, bus.rlast, mem_cs, bus.rresp, bus.rid}),
            64'({1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}));
        chk("reset_rdata", 64'(bus.rdata), 64'(0));
        chk("reset_mem_raddr", 64'(mem_raddr), 64'(0));
        @(posedge clk);
        #1 clr = 1'b0;
        @(posedge clk);
        #1;

        // first-beat latency and beat period on INCR len3 size1
        a = '{1'b0, 32'h0, 4'd3, 2'd1, BURST_INCR};
        send_ar(a);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rvalid && n < 20);
        chk("first_beat_latency", 64'(n - 1), 64'(3));
        m = 0;
        do begin @(negedge clk); m++; end while (!bus.rvalid && m < 20);
        chk("beat_period", 64'(m), 64'(3));
        drain("incr_basic");
        clear_q();

        // stall at beat 2: outputs held, no memory access
        send_ar(a);
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.rvalid && bus.rready) && n < 50);
        rr_force = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rvalid && n < 50);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_hold%0d", k), 64'({bus.rvalid, bus.rlast, mem_cs, bus.rid, bus.rdata}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h2}));
            @(negedge clk);
        end
        rr_force = 1'b1;
        drain("stall");
        clear_q();

        // fill the queue behind a stalled burst; arready must drop
        rr_force = 1'b0;
        send_ar('{1'b0, 32'h08, 4'd2, 2'd2, BURST_INCR});
        send_ar('{1'b1, 32'h14, 4'd1, 2'd0, BURST_INCR});
        send_ar('{1'b0, 32'h30, 4'd0, 2'd2, BURST_INCR});
        a = '{1'b1, 32'h40, 4'd1, 2'd2, BURST_INCR};
        bus.arvalid = 1'b1;
        bus.arid    = a.id;
        bus.araddr  = a.addr;
        bus.arlen   = a.len;
        bus.arsize  = a.size;
        bus.arburst = a.burst;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("full_arready%0d", k), 64'(bus.arready), 64'(0));
        end
        rr_force = 1'b1;
        send_ar(a);
        drain("fifo_full");
        clear_q();

        // directed table
        tbl.push_back('{'{1'b0, 32'h00, 4'd3, 2'd1, BURST_INCR},  4, 32'h00, 32'h06, 2'd0});
        tbl.push_back('{'{1'b1, 32'h1E, 4'd2, 2'd2, BURST_FIXED}, 3, 32'h1E, 32'h1E, 2'd0});
`ifdef AXI_RS_WRAP_EN
        tbl.push_back('{'{1'b0, 32'h0C, 4'd3, 2'd2, BURST_WRAP},  4, 32'h0C, 32'h08, 2'd0});
        tbl.push_back('{'{1'b1, 32'h05, 4'd1, 2'd0, BURST_WRAP},  2, 32'h05, 32'h04, 2'd0});
`else
        tbl.push_back('{'{1'b0, 32'h0C, 4'd3, 2'd2, BURST_WRAP},  4, 32'h00, 32'h00, 2'd2});
        tbl.push_back('{'{1'b1, 32'h05, 4'd1, 2'd0, BURST_WRAP},  2, 32'h00, 32'h00, 2'd2});
`endif
        tbl.push_back('{'{1'b1, 32'h10, 4'd1, 2'd3, BURST_INCR},  2, 32'h00, 32'h00, 2'd2});
        tbl.push_back('{'{1'b0, 32'h10, 4'd0, 2'd2, 2'd3},        1, 32'h00, 32'h00, 2'd2});
        tbl.push_back('{'{1'b1, 32'h20, 4'd0, 2'd0, BURST_INCR},  1, 32'h20, 32'h20, 2'd0});
        tbl.push_back('{'{1'b0, 32'h03, 4'd1, 2'd2, BURST_INCR},  2, 32'h03, 32'h07, 2'd0});
        tbl.push_back('{'{1'b1, 32'hFFFFFF7E, 4'd1, 2'd1, BURST_INCR}, 2, 32'h7E, 32'h00, 2'd0});
        tbl.push_back('{'{1'b0, 32'h04, 4'd2, 2'd2, BURST_WRAP},  3, 32'h00, 32'h00, 2'd2});
        tbl.push_back('{'{1'b1, 32'h40, 4'd15, 2'd2, BURST_INCR}, 16, 32'h40, 32'h7C, 2'd0});
        for (int i = 0; i < tbl.size(); i++) begin
            send_ar(tbl[i].ar);
            drain($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d nbeats", i), 64'(act_q.size()), 64'(tbl[i].nb));
            if (act_q.size() > 0) begin
                chk($sformatf("tbl%0d first_data", i), 64'(act_q[0].data), 64'(tbl[i].first));
                chk($sformatf("tbl%0d last_data", i), 64'(act_q[$].data), 64'(tbl[i].last));
                chk($sformatf("tbl%0d resp", i), 64'(act_q[$].resp), 64'(tbl[i].resp));
            end
            clear_q();
        end

        // reset in the middle of a burst
        send_ar('{1'b1, 32'h00, 4'd3, 2'd1, BURST_INCR});
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.rvalid && bus.rready) && n < 50);
        rr_force = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
        #2 clr = 1'b1;
        #1;
        chk("clr_outputs", 64'({bus.rvalid, mem_cs, bus.arready, bus.rlast}),
            64'({1'b0, 1'b0, 1'b1, 1'b0}));
        @(posedge clk);
        #1 clr = 1'b0;
        rr_force = 1'b1;
        clear_q();
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rvalid || mem_cs) n++;
        end
        chk("post_clr_activity", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        send_ar('{1'b0, 32'h10, 4'd1, 2'd2, BURST_INCR});
        drain("after_clr");
        clear_q();

        // randomized traffic with random backpressure
        rr_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a.id    = IW'($urandom);
            a.addr  = $urandom;
            a.len   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            a.size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a.burst = 2'($urandom_range(0, 3));
            send_ar(a);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain("random");
        clear_q();
        rr_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
